// File: rtl/amm_transmitter.sv
// Avalon-MM command issuer: write bursts of pattern data or read bursts, plus compare descriptors.
// Latency: 1 cycle from command accept to first write request; reads pass through RD_WAIT first.
// Backpressure: waitrequest holds all request outputs; reads stall until in-flight words fit MAX_RD_WORDS.
//
// Ports: clk_i/rst_n_i (async active-low), start_test_i clears stats and in-flight count,
//        cmd_* command handshake, amm_* Avalon-MM master, cmp_* one-cycle read descriptor.
// Optional macro TX_STAT_EN adds stat_wr_words_o / stat_rd_cmds_o saturating counters.
module amm_transmitter #(
    parameter  int AMM_DATA_W   = 128,
    parameter  int ADDR_W       = 32,
    parameter  int AMM_BURST_W  = 11,
    parameter  int MAX_RD_WORDS = 64,
    localparam int DATA_B_W     = AMM_DATA_W / 8,
    localparam int ADDR_B_W     = $clog2(DATA_B_W)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_test_i,

    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_op_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [AMM_BURST_W-2:0]     cmd_words_i,
    input  logic [ADDR_B_W-1:0]        cmd_start_off_i,
    input  logic [ADDR_B_W-1:0]        cmd_end_off_i,
    input  logic                       cmd_rnd_i,
    input  logic [7:0]                 cmd_ptrn_i,

    output logic [ADDR_W-ADDR_B_W-1:0] amm_address_o,
    output logic                       amm_read_o,
    output logic                       amm_write_o,
    output logic [AMM_DATA_W-1:0]      amm_writedata_o,
    output logic [DATA_B_W-1:0]        amm_byteenable_o,
    output logic [AMM_BURST_W-1:0]     amm_burstcount_o,
    input  logic                       amm_waitrequest_i,
    input  logic                       amm_readdatavalid_i,

    output logic                       cmp_en_o,
    output logic [ADDR_W-1:0]          cmp_addr_o,
    output logic [AMM_BURST_W-2:0]     cmp_words_o,
    output logic [ADDR_B_W-1:0]        cmp_start_off_o,
    output logic [ADDR_B_W-1:0]        cmp_end_off_o,
    output logic                       cmp_rnd_o,
    output logic [7:0]                 cmp_ptrn_o
`ifdef TX_STAT_EN
    ,
    output logic [31:0]                stat_wr_words_o,
    output logic [31:0]                stat_rd_cmds_o
`endif
);

    localparam int CNT_W = $clog2(MAX_RD_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RD} state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      cmd_addr_q;
    logic [AMM_BURST_W-2:0] cmd_words_q;
    logic [ADDR_B_W-1:0]    cmd_start_off_q;
    logic [ADDR_B_W-1:0]    cmd_end_off_q;
    logic                   cmd_rnd_q;
    logic [7:0]             cmd_ptrn_q;
    logic [AMM_BURST_W-2:0] beat_cnt_q;
    logic [7:0]             pattern_q;
    logic [CNT_W-1:0]       inflight_q;

    logic                   rd_acc;
    logic                   wr_acc;
    logic [AMM_BURST_W-1:0] burst_len;
    logic [31:0]            rd_need;
    logic                   credit_ok;
    logic [7:0]             pattern_nxt;

    // Byte lane i is enabled when it lies at/after start_off on the first beat
    // and at/before end_off on the last beat; a single beat applies both limits.
    function automatic logic [DATA_B_W-1:0] lane_mask(
        input logic                first,
        input logic                last,
        input logic [ADDR_B_W-1:0] so,
        input logic [ADDR_B_W-1:0] eo
    );
        logic [DATA_B_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_B_W; i++) begin
            m[i] = (!first || (ADDR_B_W'(i) >= so)) && (!last || (ADDR_B_W'(i) <= eo));
        end
        return m;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

    assign rd_acc      = amm_read_o  && !amm_waitrequest_i;
    assign wr_acc      = amm_write_o && !amm_waitrequest_i;
    assign burst_len   = {1'b0, cmd_words_q} + AMM_BURST_W'(1);
    // Sum computed wide so a long burst cannot wrap the comparison.
    assign rd_need     = 32'(inflight_q) + 32'(burst_len);
    assign credit_ok   = (rd_need <= 32'(MAX_RD_WORDS));
    assign pattern_nxt = cmd_rnd_q ? lfsr_step(pattern_q) : pattern_q;

    // In-flight read words: add the burst on read accept, retire one per returned word.
    // A returned word with nothing outstanding is ignored so the count cannot underflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
        end else if (start_test_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q
                        + (rd_acc ? CNT_W'(burst_len) : CNT_W'(0))
                        - ((amm_readdatavalid_i && (inflight_q != '0)) ? CNT_W'(1) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= IDLE;
            cmd_ready_o      <= 1'b1;
            cmd_addr_q       <= '0;
            cmd_words_q      <= '0;
            cmd_start_off_q  <= '0;
            cmd_end_off_q    <= '0;
            cmd_rnd_q        <= 1'b0;
            cmd_ptrn_q       <= '0;
            beat_cnt_q       <= '0;
            pattern_q        <= '0;
            amm_address_o    <= '0;
            amm_read_o       <= 1'b0;
            amm_write_o      <= 1'b0;
            amm_writedata_o  <= '0;
            amm_byteenable_o <= '0;
            amm_burstcount_o <= '0;
            cmp_en_o         <= 1'b0;
            cmp_addr_o       <= '0;
            cmp_words_o      <= '0;
            cmp_start_off_o  <= '0;
            cmp_end_off_o    <= '0;
            cmp_rnd_o        <= 1'b0;
            cmp_ptrn_o       <= '0;
        end else begin
            cmp_en_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o      <= 1'b0;
                        cmd_addr_q       <= cmd_addr_i;
                        cmd_words_q      <= cmd_words_i;
                        cmd_start_off_q  <= cmd_start_off_i;
                        cmd_end_off_q    <= cmd_end_off_i;
                        cmd_rnd_q        <= cmd_rnd_i;
                        cmd_ptrn_q       <= cmd_ptrn_i;
                        amm_address_o    <= cmd_addr_i[ADDR_W-1:ADDR_B_W];
                        amm_burstcount_o <= {1'b0, cmd_words_i} + AMM_BURST_W'(1);
                        if (!cmd_op_i) begin
                            // First write beat goes out on the next cycle with the seed pattern.
                            state_q          <= WR;
                            amm_write_o      <= 1'b1;
                            beat_cnt_q       <= cmd_words_i;
                            pattern_q        <= cmd_ptrn_i;
                            amm_writedata_o  <= {DATA_B_W{cmd_ptrn_i}};
                            amm_byteenable_o <= lane_mask(1'b1, cmd_words_i == '0,
                                                          cmd_start_off_i, cmd_end_off_i);
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (credit_ok) begin
                        state_q    <= RD;
                        amm_read_o <= 1'b1;
                    end
                end
                RD: begin
                    if (rd_acc) begin
                        state_q          <= IDLE;
                        cmd_ready_o      <= 1'b1;
                        amm_read_o       <= 1'b0;
                        amm_address_o    <= '0;
                        amm_burstcount_o <= '0;
                        cmp_en_o         <= 1'b1;
                        cmp_addr_o       <= cmd_addr_q;
                        cmp_words_o      <= cmd_words_q;
                        cmp_start_off_o  <= cmd_start_off_q;
                        cmp_end_off_o    <= cmd_end_off_q;
                        cmp_rnd_o        <= cmd_rnd_q;
                        cmp_ptrn_o       <= cmd_ptrn_q;
                    end
                end
                WR: begin
                    if (wr_acc) begin
                        if (beat_cnt_q == '0) begin
                            state_q          <= IDLE;
                            cmd_ready_o      <= 1'b1;
                            amm_write_o      <= 1'b0;
                            amm_writedata_o  <= '0;
                            amm_byteenable_o <= '0;
                            amm_address_o    <= '0;
                            amm_burstcount_o <= '0;
                        end else begin
                            beat_cnt_q       <= beat_cnt_q - 1'b1;
                            pattern_q        <= pattern_nxt;
                            amm_writedata_o  <= {DATA_B_W{pattern_nxt}};
                            // Next beat is the last when the count about to be loaded reaches zero.
                            amm_byteenable_o <= lane_mask(1'b0, beat_cnt_q == AMM_BURST_W'(1),
                                                          cmd_start_off_q, cmd_end_off_q);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_o <= 1'b1;
                end
            endcase
        end
    end

`ifdef TX_STAT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_wr_words_o <= '0;
            stat_rd_cmds_o  <= '0;
        end else if (start_test_i) begin
            stat_wr_words_o <= '0;
            stat_rd_cmds_o  <= '0;
        end else begin
            if (wr_acc && (stat_wr_words_o != '1)) stat_wr_words_o <= stat_wr_words_o + 1'b1;
            if (rd_acc && (stat_rd_cmds_o  != '1)) stat_rd_cmds_o  <= stat_rd_cmds_o  + 1'b1;
        end
    end
`endif

endmodule
